// File: rtl/prog_seq_ctrl.sv
// prog_seq_ctrl -- launch controller between the top-level req/ack handshake
// and the core's program counter. Each accepted req selects the next program
// in a 0..NUM_PROGS-1 rotation. It then strobes that program's start address
// into the PC and holds the core in run until halt. The controller counts run
// cycles and raises ack when the program completes.
//
// Optional build macro: PROG_SEQ_WDOG_EN
//   defined   -> RUN also ends when run_cycles reaches WDOG_LIMIT; timeout flags it
//   undefined -> no watchdog, timeout tied to 0
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   req        in   start-next-program request
//   halt       in   core reached its halt instruction (sampled only in RUN)
//   pc_load    out  one-cycle strobe, core loads pc_start into its PC
//   pc_start   out  start address of the selected program (PC_W)
//   run        out  core enable
//   prog_idx   out  index of the current or most recent program (2 bits)
//   ack        out  program complete, held until the next req is accepted
//   run_cycles out  run cycles of the current or last program (CYC_W, saturating)
//   timeout    out  last program ended by watchdog
//
// state | meaning
// IDLE  | after reset, waiting for the first req
// LOAD  | one cycle: pc_load strobe, counters cleared
// RUN   | core enabled, counting cycles until halt (or watchdog)
// DONE  | ack high, prog_idx advanced, waiting for the next req

module prog_seq_ctrl #(
  parameter int unsigned NUM_PROGS = 3,
  parameter int unsigned PC_W = 10,
  // Entry k sits at bits [k*PC_W +: PC_W], so program 0 is in the LSBs.
  parameter logic [4*PC_W-1:0] START_ADDRS = {10'd384, 10'd256, 10'd128, 10'd0},
  parameter int unsigned CYC_W = 16
`ifdef PROG_SEQ_WDOG_EN
  ,
  parameter logic [CYC_W-1:0] WDOG_LIMIT = 16'd50000
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             halt,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_start,
  output logic             run,
  output logic [1:0]       prog_idx,
  output logic             ack,
  output logic [CYC_W-1:0] run_cycles,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  state_t           state;
  logic [CYC_W-1:0] cyc_nxt;
  logic [1:0]       idx_nxt;

  function automatic logic [PC_W-1:0] start_addr(input logic [1:0] idx);
    return START_ADDRS[int'(idx)*PC_W +: PC_W];
  endfunction

  assign cyc_nxt = (run_cycles == '1) ? run_cycles : run_cycles + 1'b1;
  assign idx_nxt = (prog_idx == LAST_IDX) ? 2'd0 : prog_idx + 2'd1;

`ifndef PROG_SEQ_WDOG_EN
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      prog_idx   <= 2'd0;
      pc_load    <= 1'b0;
      run        <= 1'b0;
      ack        <= 1'b0;
      run_cycles <= '0;
      pc_start   <= start_addr(2'd0);
`ifdef PROG_SEQ_WDOG_EN
      timeout    <= 1'b0;
`endif
    end else begin
      pc_load <= 1'b0;
      case (state)
        // prog_idx already points at the next program when DONE is entered,
        // so both waiting states launch the same way.
        S_IDLE, S_DONE: begin
          if (req) begin
            state      <= S_LOAD;
            pc_load    <= 1'b1;
            pc_start   <= start_addr(prog_idx);
            ack        <= 1'b0;
            run_cycles <= '0;
`ifdef PROG_SEQ_WDOG_EN
            timeout    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          state <= S_RUN;
          run   <= 1'b1;
        end
        S_RUN: begin
          // The halt edge still closes a run cycle, so it is counted too.
          run_cycles <= cyc_nxt;
          if (halt) begin
            state    <= S_DONE;
            run      <= 1'b0;
            ack      <= 1'b1;
            prog_idx <= idx_nxt;
          end
`ifdef PROG_SEQ_WDOG_EN
          else if (cyc_nxt == WDOG_LIMIT) begin
            state    <= S_DONE;
            run      <= 1'b0;
            ack      <= 1'b1;
            prog_idx <= idx_nxt;
            timeout  <= 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Directed bench for prog_seq_ctrl. Inputs are driven and outputs sampled on
// the falling edge of clk, away from the active edge.

module tb_prog_seq_ctrl;

  localparam int PC_W  = 10;
  localparam int CYC_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req = 1'b0;
  logic             halt = 1'b0;
  logic             pc_load;
  logic [PC_W-1:0]  pc_start;
  logic             run;
  logic [1:0]       prog_idx;
  logic             ack;
  logic [CYC_W-1:0] run_cycles;
  logic             timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prog_seq_ctrl #(
    .NUM_PROGS (3),
    .PC_W      (PC_W),
    .CYC_W     (CYC_W)
`ifdef PROG_SEQ_WDOG_EN
    ,
    .WDOG_LIMIT(16'd100)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .halt      (halt),
    .pc_load   (pc_load),
    .pc_start  (pc_start),
    .run       (run),
    .prog_idx  (prog_idx),
    .ack       (ack),
    .run_cycles(run_cycles),
    .timeout   (timeout)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse req for one cycle; check the LOAD cycle, then the first run cycle.
  task automatic launch(input int exp_pc);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk_eq("load_pc_load", 32'(pc_load), 1);
    chk_eq("load_pc_start", 32'(pc_start), exp_pc);
    chk_eq("load_run", 32'(run), 0);
    chk_eq("load_ack", 32'(ack), 0);
    chk_eq("load_cycles", 32'(run_cycles), 0);
    chk_eq("load_timeout", 32'(timeout), 0);
    @(negedge clk);
    chk_eq("run_on", 32'(run), 1);
    chk_eq("run_pc_load", 32'(pc_load), 0);
  endtask

  // Called in run cycle 1; halts so that exactly n cycles had run=1.
  task automatic finish_after(input int n, input int exp_idx);
    repeat (n - 1) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk_eq("done_ack", 32'(ack), 1);
    chk_eq("done_run", 32'(run), 0);
    chk_eq("done_cycles", 32'(run_cycles), n);
    chk_eq("done_idx", 32'(prog_idx), exp_idx);
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk_eq("rst_pc_load", 32'(pc_load), 0);
    chk_eq("rst_run", 32'(run), 0);
    chk_eq("rst_ack", 32'(ack), 0);
    chk_eq("rst_idx", 32'(prog_idx), 0);
    chk_eq("rst_cycles", 32'(run_cycles), 0);
    chk_eq("rst_pc_start", 32'(pc_start), 0);
    chk_eq("rst_timeout", 32'(timeout), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("idle_run", 32'(run), 0);
    chk_eq("idle_pc_load", 32'(pc_load), 0);

    // first program, 20 run cycles
    launch(0);
    finish_after(20, 1);
    repeat (2) begin
      @(negedge clk);
      chk_eq("hold_ack", 32'(ack), 1);
      chk_eq("hold_cycles", 32'(run_cycles), 20);
      chk_eq("hold_pc_start", 32'(pc_start), 0);
    end

    // rotation 1 -> 2 -> 0 -> 1
    launch(128);
    finish_after(5, 2);
    launch(256);
    finish_after(3, 0);
    launch(0);
    finish_after(1, 1);

    // req pulses during RUN are ignored
    launch(128);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk_eq("runreq_pc_load", 32'(pc_load), 0);
    chk_eq("runreq_run", 32'(run), 1);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk_eq("runreq2_pc_load", 32'(pc_load), 0);
    chk_eq("runreq2_run", 32'(run), 1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk_eq("runreq_ack", 32'(ack), 1);
    chk_eq("runreq_cycles", 32'(run_cycles), 4);
    chk_eq("runreq_idx", 32'(prog_idx), 2);
    repeat (3) begin
      @(negedge clk);
      chk_eq("noqueue_pc_load", 32'(pc_load), 0);
      chk_eq("noqueue_ack", 32'(ack), 1);
    end

    // halt and req on the same edge: halt wins, req not retained
    launch(256);
    @(negedge clk);
    halt = 1'b1;
    req = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    req = 1'b0;
    chk_eq("both_ack", 32'(ack), 1);
    chk_eq("both_run", 32'(run), 0);
    chk_eq("both_cycles", 32'(run_cycles), 2);
    chk_eq("both_idx", 32'(prog_idx), 0);
    repeat (3) begin
      @(negedge clk);
      chk_eq("both_no_load", 32'(pc_load), 0);
      chk_eq("both_hold_ack", 32'(ack), 1);
    end

    // req still high when DONE is entered launches the next program at once
    launch(0);
    halt = 1'b1;
    req = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk_eq("held_ack", 32'(ack), 1);
    chk_eq("held_cycles", 32'(run_cycles), 1);
    chk_eq("held_idx", 32'(prog_idx), 1);
    @(negedge clk);
    req = 1'b0;
    chk_eq("held_pc_load", 32'(pc_load), 1);
    chk_eq("held_pc_start", 32'(pc_start), 128);
    chk_eq("held_ack_low", 32'(ack), 0);
    @(negedge clk);
    chk_eq("held_run", 32'(run), 1);
    finish_after(2, 2);

    // reset mid-RUN of program 1
    launch(256);
    finish_after(1, 0);
    launch(0);
    finish_after(1, 1);
    launch(128);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_eq("arst_run", 32'(run), 0);
    chk_eq("arst_ack", 32'(ack), 0);
    chk_eq("arst_idx", 32'(prog_idx), 0);
    chk_eq("arst_pc_start", 32'(pc_start), 0);
    chk_eq("arst_cycles", 32'(run_cycles), 0);
    @(negedge clk);
    reset = 1'b1;
    launch(0);
    finish_after(3, 1);

`ifdef PROG_SEQ_WDOG_EN
    // watchdog at 100 run cycles
    launch(128);
    repeat (99) @(negedge clk);
    chk_eq("wdog_pre_run", 32'(run), 1);
    chk_eq("wdog_pre_cycles", 32'(run_cycles), 99);
    @(negedge clk);
    chk_eq("wdog_ack", 32'(ack), 1);
    chk_eq("wdog_run", 32'(run), 0);
    chk_eq("wdog_timeout", 32'(timeout), 1);
    chk_eq("wdog_cycles", 32'(run_cycles), 100);
    chk_eq("wdog_idx", 32'(prog_idx), 2);
    launch(256);
    finish_after(1, 0);
`else
    // without the watchdog a long run keeps going until halt
    launch(128);
    repeat (149) @(negedge clk);
    chk_eq("long_run", 32'(run), 1);
    chk_eq("long_timeout", 32'(timeout), 0);
    repeat (50) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk_eq("long_ack", 32'(ack), 1);
    chk_eq("long_cycles", 32'(run_cycles), 200);
    chk_eq("long_idx", 32'(prog_idx), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
